// File: rtl/trace_replay_engine_pkg.sv
// Shared definitions for the trace replay sequencer: instruction opcodes and
// the ROM word layout {op, payload}.
package trace_replay_engine_pkg;

  localparam int unsigned op_width_lp = 4;

  typedef enum logic [3:0] {
    OP_NOP          = 4'd0,
    OP_SEND         = 4'd1,
    OP_RECV         = 4'd2,
    OP_DONE         = 4'd3,
    OP_FINISH       = 4'd4,
    OP_WAIT         = 4'd5,
    OP_LDCNT        = 4'd6,
    OP_RECV_NOCHECK = 4'd7
  } op_e;

  // Width of one ROM word: opcode on top of a single packet payload.
  function automatic int unsigned rom_word_width(input int unsigned ring_width);
    return ring_width + op_width_lp;
  endfunction

endpackage

// File: rtl/trace_replay_engine_wait_counter.sv
// Down-counter used by the WAIT instruction: loaded by LDCNT, decremented
// while a WAIT is stalling, and reporting when it has reached zero.
module trace_replay_engine_wait_counter #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  input  logic [width_p-1:0] load_value,
  output logic               zero
);

  logic [width_p-1:0] count;

  // Load has priority; the sequencer never requests load and dec together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - width_p'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/trace_replay_engine.sv
// ROM-driven stimulus/check sequencer. Each ROM word holds an opcode and a
// packet payload; the engine sends payloads out, compares incoming packets,
// waits on a loadable counter and stops on DONE/FINISH or an illegal opcode.
module trace_replay_engine
  import trace_replay_engine_pkg::*;
#(
  parameter int unsigned ring_width_p     = 80,
  parameter int unsigned rom_addr_width_p = 8,
  parameter int unsigned counter_width_p  = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  en_i,
  input  logic                                  v_i,
  input  logic [ring_width_p-1:0]               data_i,
  output logic                                  ready_o,
  output logic                                  v_o,
  output logic [ring_width_p-1:0]               data_o,
  input  logic                                  yumi_i,
  output logic [rom_addr_width_p-1:0]           rom_addr_o,
  input  logic [rom_word_width(ring_width_p)-1:0] rom_data_i,
  output logic                                  done_o,
  output logic                                  error_o
);

  logic [op_width_lp-1:0]      op_bits;
  op_e                         op;
  logic [ring_width_p-1:0]     payload;
  logic [rom_addr_width_p-1:0] addr;
  logic                        done_q;
  logic                        error_q;
  logic                        active;
  logic                        advance;
  logic                        set_done;
  logic                        set_error;
  logic                        cnt_load;
  logic                        cnt_dec;
  logic                        cnt_zero;

  assign op_bits = rom_data_i[ring_width_p +: op_width_lp];
  assign op      = op_e'(op_bits);
  assign payload = rom_data_i[ring_width_p-1:0];
  assign active  = en_i && !done_q && !reset_i;

  // Decode the current instruction into handshake outputs and state updates.
  // FINISH behaves exactly like DONE in hardware; encodings 8-15 stop with error.
  always_comb begin
    v_o       = 1'b0;
    ready_o   = 1'b0;
    advance   = 1'b0;
    set_done  = 1'b0;
    set_error = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (active) begin
      case (op)
        OP_NOP: advance = 1'b1;
        OP_SEND: begin
          v_o     = 1'b1;
          advance = yumi_i;
        end
        OP_RECV: begin
          ready_o   = 1'b1;
          advance   = v_i;
          set_error = v_i && (data_i != payload);
        end
        OP_DONE, OP_FINISH: set_done = 1'b1;
        OP_WAIT: begin
          advance = cnt_zero;
          cnt_dec = !cnt_zero;
        end
        OP_LDCNT: begin
          cnt_load = 1'b1;
          advance  = 1'b1;
        end
        OP_RECV_NOCHECK: begin
          ready_o = 1'b1;
          advance = v_i;
        end
        default: begin
          set_done  = 1'b1;
          set_error = 1'b1;
        end
      endcase
    end
  end

  // Instruction pointer plus sticky done/error flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (advance)   addr    <= addr + rom_addr_width_p'(1);
      if (set_done)  done_q  <= 1'b1;
      if (set_error) error_q <= 1'b1;
    end
  end

  trace_replay_engine_wait_counter #(
    .width_p(counter_width_p)
  ) wait_counter (
    .clk        (clk_i),
    .reset      (reset_i),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (payload[counter_width_p-1:0]),
    .zero       (cnt_zero)
  );

  assign data_o     = payload;
  assign rom_addr_o = addr;
  assign done_o     = done_q;
  assign error_o    = error_q;

  // A consumer may only take data that is actually being offered.
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i || !en_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_trace_replay_engine.sv
// Bench for trace_replay_engine: directed scenarios plus randomized programs
// checked against a program-level model (sent payload order, final error,
// terminating address).
module tb_trace_replay_engine;

  localparam int unsigned W  = 80;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  localparam logic [3:0] NOP    = 4'd0;
  localparam logic [3:0] SEND   = 4'd1;
  localparam logic [3:0] RECV   = 4'd2;
  localparam logic [3:0] DONE   = 4'd3;
  localparam logic [3:0] FINISH = 4'd4;
  localparam logic [3:0] WAIT   = 4'd5;
  localparam logic [3:0] LDCNT  = 4'd6;
  localparam logic [3:0] RECVNC = 4'd7;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b1;
  logic          v_i = 1'b0;
  logic          yumi_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o, v_o, done_o, error_o;
  logic [W-1:0]  data_o;
  logic [AW-1:0] rom_addr_o;
  logic [W+3:0]  rom_data_i;
  logic [W+3:0]  rom [256];

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  bit auto_drive = 1'b0;

  always #5 clk = ~clk;

  always_comb rom_data_i = rom[rom_addr_o];

  trace_replay_engine #(
    .ring_width_p     (W),
    .rom_addr_width_p (AW),
    .counter_width_p  (CW)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+3:0] word(input logic [3:0] op, input logic [W-1:0] p);
    return {op, p};
  endfunction

  function automatic logic [W-1:0] rnd_payload();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = word(DONE, '0);
  endtask

  // Enter reset and return on the next falling edge, with the address at 0,
  // so the caller can load a program before releasing reset.
  task automatic start_reset();
    @(negedge clk);
    auto_drive = 1'b0;
    reset_i = 1'b1;
    en_i    = 1'b1;
    yumi_i  = 1'b0;
    v_i     = 1'b0;
    data_i  = '0;
    @(negedge clk);
    clear_rom();
  endtask

  // Scoreboard monitor: pops the expected payload on every accepted send and
  // consumes receive stimulus on every accepted receive.
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset_i) begin
      if (v_o || ready_o) chk("v_o_ready_o_exclusive", 96'(v_o & ready_o), 96'(0));
      if (en_i && v_o && yumi_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_send: got %0h expected no send", data_o);
        end else begin
          chk("send_data", 96'(data_o), 96'(exp_q.pop_front()));
        end
      end
      if (en_i && ready_o && v_i && rx_q.size() > 0) void'(rx_q.pop_front());
    end
  end

  // Random driver: toggles enable, backpressures sends, delays receives.
  initial forever begin
    @(negedge clk);
    if (auto_drive) begin
      en_i = ($urandom_range(0, 7) != 0);
      #1;
      yumi_i = v_o && ($urandom_range(0, 3) != 0);
      v_i    = ready_o && (rx_q.size() > 0) && ($urandom_range(0, 2) != 0);
      data_i = (rx_q.size() > 0) ? rx_q[0] : '0;
    end
  end

  // Reference model: builds a program and records, at program level, what the
  // engine must send, what it will be fed, whether it must flag an error and
  // where it must stop.
  task automatic gen_program(output int unsigned term, output bit exp_err);
    int unsigned idx;
    int unsigned n;
    logic [W-1:0] one;
    idx = 0;
    n = $urandom_range(4, 20);
    one = 1;
    exp_err = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      logic [W-1:0] p;
      bit bad;
      p = rnd_payload();
      case ($urandom_range(0, 5))
        0: begin rom[idx] = word(NOP, p); idx++; end
        1: begin rom[idx] = word(SEND, p); idx++; exp_q.push_back(p); end
        2: begin
          bad = ($urandom_range(0, 3) == 0);
          rom[idx] = word(RECV, p); idx++;
          rx_q.push_back(bad ? (p ^ (one << $urandom_range(0, W - 1))) : p);
          if (bad) exp_err = 1'b1;
        end
        3: begin
          rom[idx] = word(LDCNT, {p[W-1:CW], CW'($urandom_range(0, 6))}); idx++;
          rom[idx] = word(WAIT, p); idx++;
        end
        4: begin rom[idx] = word(RECVNC, p); idx++; rx_q.push_back(rnd_payload()); end
        default: begin rom[idx] = word(SEND, p); idx++; exp_q.push_back(p); end
      endcase
    end
    case ($urandom_range(0, 2))
      0: rom[idx] = word(DONE, rnd_payload());
      1: rom[idx] = word(FINISH, rnd_payload());
      default: begin
        rom[idx] = word(4'($urandom_range(8, 15)), rnd_payload());
        exp_err = 1'b1;
      end
    endcase
    term = idx;
  endtask

  initial begin
    int unsigned term;
    bit exp_err;
    int cyc;

    clear_rom();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_addr", 96'(rom_addr_o), 96'(0));
    chk("reset_done", 96'(done_o), 96'(0));
    chk("reset_error", 96'(error_o), 96'(0));
    chk("reset_v_o", 96'(v_o), 96'(0));
    chk("reset_ready_o", 96'(ready_o), 96'(0));

    // SEND held for three cycles of backpressure, taken on the fourth.
    start_reset();
    rom[0] = word(SEND, 80'h1234);
    exp_q.push_back(80'h1234);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      yumi_i = (i == 3);
      #1;
      chk("t1_v_o", 96'(v_o), 96'(1));
      chk("t1_addr", 96'(rom_addr_o), 96'(0));
      chk("t1_data", 96'(data_o), 96'h1234);
      @(negedge clk);
    end
    yumi_i = 1'b0;
    #1;
    chk("t1_addr_adv", 96'(rom_addr_o), 96'(1));
    chk("t1_v_o_drop", 96'(v_o), 96'(0));
    @(negedge clk); #1;
    chk("t1_done", 96'(done_o), 96'(1));
    chk("t1_queue", 96'(exp_q.size()), 96'(0));

    // RECV match then mismatch; error is sticky.
    start_reset();
    rom[0] = word(RECV, 80'hAB);
    rom[1] = word(RECV, 80'hAB);
    rom[2] = word(NOP, '0);
    reset_i = 1'b0;
    #1;
    chk("t2_ready", 96'(ready_o), 96'(1));
    chk("t2_v_o", 96'(v_o), 96'(0));
    @(negedge clk); #1;
    chk("t2_hold_no_v_i", 96'(rom_addr_o), 96'(0));
    @(negedge clk);
    v_i = 1'b1; data_i = 80'hAB;
    @(negedge clk);
    data_i = 80'hAC;
    #1;
    chk("t2_match_error", 96'(error_o), 96'(0));
    chk("t2_match_addr", 96'(rom_addr_o), 96'(1));
    @(negedge clk);
    v_i = 1'b0;
    #1;
    chk("t2_mismatch_error", 96'(error_o), 96'(1));
    chk("t2_mismatch_addr", 96'(rom_addr_o), 96'(2));
    repeat (4) @(negedge clk);
    #1;
    chk("t2_sticky_error", 96'(error_o), 96'(1));
    chk("t2_done", 96'(done_o), 96'(1));

    // LDCNT 5 then WAIT holds six cycles; WAIT with zero count passes through.
    start_reset();
    rom[0] = word(LDCNT, {64'hFFFF_0000_FFFF_0000, 16'd5});
    rom[1] = word(WAIT, '0);
    rom[2] = word(WAIT, '0);
    reset_i = 1'b0;
    #1;
    chk("t3_addr0", 96'(rom_addr_o), 96'(0));
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_wait_hold", 96'(rom_addr_o), 96'(1));
      @(negedge clk);
    end
    #1;
    chk("t3_wait_release", 96'(rom_addr_o), 96'(2));
    @(negedge clk); #1;
    chk("t3_zero_wait", 96'(rom_addr_o), 96'(3));
    @(negedge clk); #1;
    chk("t3_done", 96'(done_o), 96'(1));

    // Back-to-back sends then DONE; address freezes at the DONE.
    start_reset();
    rom[0] = word(SEND, 80'hA0A0);
    rom[1] = word(SEND, 80'hB1B1);
    exp_q.push_back(80'hA0A0);
    exp_q.push_back(80'hB1B1);
    reset_i = 1'b0;
    yumi_i = 1'b1;
    #1;
    chk("t4_v_o0", 96'(v_o), 96'(1));
    chk("t4_addr0", 96'(rom_addr_o), 96'(0));
    @(negedge clk); #1;
    chk("t4_v_o1", 96'(v_o), 96'(1));
    chk("t4_addr1", 96'(rom_addr_o), 96'(1));
    @(negedge clk);
    yumi_i = 1'b0;
    #1;
    chk("t4_addr2", 96'(rom_addr_o), 96'(2));
    chk("t4_not_done_yet", 96'(done_o), 96'(0));
    @(negedge clk); #1;
    chk("t4_done", 96'(done_o), 96'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("t4_frozen", 96'(rom_addr_o), 96'(2));
    chk("t4_queue", 96'(exp_q.size()), 96'(0));

    // Enable low freezes a pending SEND even with yumi asserted.
    start_reset();
    rom[0] = word(SEND, 80'hC5);
    exp_q.push_back(80'hC5);
    reset_i = 1'b0;
    en_i = 1'b0;
    yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_v_o_off", 96'(v_o), 96'(0));
      chk("t5_addr_hold", 96'(rom_addr_o), 96'(0));
      @(negedge clk);
    end
    en_i = 1'b1;
    #1;
    chk("t5_v_o_on", 96'(v_o), 96'(1));
    @(negedge clk);
    yumi_i = 1'b0;
    #1;
    chk("t5_addr_adv", 96'(rom_addr_o), 96'(1));
    chk("t5_queue", 96'(exp_q.size()), 96'(0));

    // Reset pulse in the middle of a long WAIT clears everything.
    start_reset();
    rom[0] = word(RECV, 80'h1);
    rom[1] = word(LDCNT, 80'd20);
    rom[2] = word(WAIT, '0);
    reset_i = 1'b0;
    v_i = 1'b1; data_i = 80'h2;
    @(negedge clk);
    v_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t6_in_wait", 96'(rom_addr_o), 96'(2));
    chk("t6_error_before", 96'(error_o), 96'(1));
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("t6_addr", 96'(rom_addr_o), 96'(0));
    chk("t6_done", 96'(done_o), 96'(0));
    chk("t6_error", 96'(error_o), 96'(0));
    chk("t6_v_o", 96'(v_o), 96'(0));

    // Reset during a pending SEND drops v_o.
    start_reset();
    rom[0] = word(SEND, 80'hE7);
    reset_i = 1'b0;
    #1;
    chk("t7_v_o_before", 96'(v_o), 96'(1));
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk); #1;
    chk("t7_v_o_reset", 96'(v_o), 96'(0));
    chk("t7_addr_reset", 96'(rom_addr_o), 96'(0));

    // Randomized programs with random enable, backpressure and receive delay.
    for (int it = 0; it < 12; it++) begin
      start_reset();
      exp_q.delete();
      rx_q.delete();
      gen_program(term, exp_err);
      reset_i = 1'b0;
      auto_drive = 1'b1;
      cyc = 0;
      while (!done_o && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
      auto_drive = 1'b0;
      #3;
      en_i = 1'b1; yumi_i = 1'b0; v_i = 1'b0;
      chk("rnd_done", 96'(done_o), 96'(1));
      chk("rnd_error", 96'(error_o), 96'(exp_err));
      chk("rnd_term_addr", 96'(rom_addr_o), 96'(term));
      chk("rnd_sends_left", 96'(exp_q.size()), 96'(0));
      chk("rnd_recvs_left", 96'(rx_q.size()), 96'(0));
      repeat (3) @(negedge clk);
      #1;
      chk("rnd_frozen", 96'(rom_addr_o), 96'(term));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
